// File: rtl/alu_ctrl_md.sv
// alu_ctrl_md: execute-stage ALU control decode plus an iterative
// RV32M multiply/divide sequencer with a stall/valid handshake.
package alu_ctrl_md_pkg;
  localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OP_OR   = 4'b0110;
  localparam logic [3:0] ALU_OP_AND  = 4'b0111;
  localparam logic [3:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [3:0] ALU_OP_EQ   = 4'b1001;
  localparam logic [3:0] ALU_OP_NEQ  = 4'b1010;
  localparam logic [3:0] ALU_OP_GE   = 4'b1011;
  localparam logic [3:0] ALU_OP_GEU  = 4'b1100;
  localparam logic [3:0] ALU_OP_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OP_XXX  = 4'b1111;
endpackage

module alu_ctrl_md
  import alu_ctrl_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      aluCtrlOp,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            valid,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [3:0]      aluOp,
  output logic            ready,
  output logic            busy,
  output logic            mdValid,
  output logic [XLEN-1:0] mdResult
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  state_t state, state_n;

  logic [CW-1:0]   cnt;
  logic [2:0]      f3;
  logic [XLEN-1:0] opa, hi, lo;
  logic            neg, rneg;

  logic            accept, special, last;
  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, spec_res;

  logic [XLEN:0]     mul_sum, div_sh, div_df;
  logic              div_ge;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo;
  logic [XLEN-1:0]   quo_s, rem_s, fin_res;
  logic [2*XLEN-1:0] prod, prod_s;

  logic unused_ok;
  assign unused_ok = ^{funct7[6], funct7[4:0], div_df[XLEN]};

  // Base-ALU op decode, independent of the sequencer
  always_comb begin
    aluOp = ALU_OP_XXX;
    case (aluCtrlOp)
      2'b00: aluOp = ALU_OP_ADD;
      2'b10: aluOp = {funct7[5], funct3};
      2'b01: begin
        case (funct3)
          3'b000:  aluOp = ALU_OP_EQ;
          3'b001:  aluOp = ALU_OP_NEQ;
          3'b100:  aluOp = ALU_OP_SLT;
          3'b101:  aluOp = ALU_OP_GE;
          3'b110:  aluOp = ALU_OP_SLTU;
          3'b111:  aluOp = ALU_OP_GEU;
          default: aluOp = ALU_OP_XXX;
        endcase
      end
      default: aluOp = ALU_OP_XXX;
    endcase
  end

  assign ready  = state == IDLE;
  assign accept = valid & ready & (aluCtrlOp == 2'b11) & ~flush;

  // Operand signedness, magnitudes and divide special cases at accept
  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    unique case (1'b1)
      funct3[2]: begin
        a_sgn = ~funct3[0];
        b_sgn = ~funct3[0];
      end
      default: begin
        a_sgn = funct3[1:0] != 2'b11;
        b_sgn = ~funct3[1];
      end
    endcase
    a_neg    = a_sgn & rs1[XLEN-1];
    b_neg    = b_sgn & rs2[XLEN-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    div_zero = rs2 == '0;
    div_ovf  = ~funct3[0]
             & (rs1 == {1'b1, {(XLEN-1){1'b0}}})
             & (&rs2);
    special  = funct3[2] & (div_zero | div_ovf);
    if (div_zero)
      spec_res = funct3[1] ? rs1 : {XLEN{1'b1}};
    else
      spec_res = funct3[1] ? '0 : rs1;
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    mul_hi  = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo[XLEN-1:1]};
    div_sh  = {hi, lo[XLEN-1]};
    div_ge  = div_sh >= {1'b0, opa};
    div_df  = div_sh - {1'b0, opa};
    div_hi  = div_ge ? div_df[XLEN-1:0] : div_sh[XLEN-1:0];
    div_lo  = {lo[XLEN-2:0], div_ge};
    prod    = {mul_hi, mul_lo};
    prod_s  = neg ? -prod : prod;
    quo_s   = neg ? -div_lo : div_lo;
    rem_s   = rneg ? -div_hi : div_hi;
    if (state == MUL)
      fin_res = (f3 == 3'b000) ? prod_s[XLEN-1:0]
                               : prod_s[2*XLEN-1:XLEN];
    else
      fin_res = f3[1] ? rem_s : quo_s;
  end

  assign last = cnt == CW'(XLEN-1);

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, stall and result strobe
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    mdValid = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          busy = 1'b1;
          if (special)        state_n = DONE;
          else if (funct3[2]) state_n = DIV;
          else                state_n = MUL;
        end
      end
      MUL, DIV: begin
        busy = 1'b1;
        if (flush)     state_n = IDLE;
        else if (last) state_n = DONE;
      end
      DONE: begin
        mdValid = ~flush;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      f3       <= '0;
      opa      <= '0;
      hi       <= '0;
      lo       <= '0;
      neg      <= 1'b0;
      rneg     <= 1'b0;
      mdResult <= '0;
    end else if (accept) begin
      cnt  <= '0;
      f3   <= funct3;
      opa  <= funct3[2] ? b_mag : a_mag;
      hi   <= '0;
      lo   <= funct3[2] ? a_mag : b_mag;
      neg  <= a_neg ^ b_neg;
      rneg <= a_neg;
      if (special) mdResult <= spec_res;
    end else if (state == MUL || state == DIV) begin
      hi <= (state == MUL) ? mul_hi : div_hi;
      lo <= (state == MUL) ? mul_lo : div_lo;
      if (!last) cnt <= cnt + CW'(1);
      if (last && !flush) mdResult <= fin_res;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// tb_alu_ctrl_md: vector table, corner sequences and random
// M ops against a plain-arithmetic reference model.
module tb_alu_ctrl_md;
  import alu_ctrl_md_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  aluCtrlOp = 2'b00;
  logic [2:0]  funct3 = 3'b000;
  logic [6:0]  funct7 = 7'b0;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [3:0]  aluOp;
  logic        ready, busy, mdValid;
  logic [31:0] mdResult;

  int errs = 0;
  int checks = 0;

  alu_ctrl_md #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .aluCtrlOp(aluCtrlOp), .funct3(funct3),
    .funct7(funct7), .valid(valid), .flush(flush),
    .rs1(rs1), .rs2(rs2), .aluOp(aluOp),
    .ready(ready), .busy(busy),
    .mdValid(mdValid), .mdResult(mdResult)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  typedef struct {
    logic [1:0] op;
    logic [2:0] f;
    logic [6:0] f7;
    logic [3:0] exp;
  } dec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = longint'(a);
    ub = longint'(b);
    ia = a;
    ib = b;
    p  = '0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Present an M op in the next cycle and leave it after the edge.
  task automatic issue(input logic [2:0] f,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    valid = 1'b1;
    aluCtrlOp = 2'b11;
    funct3 = f;
    rs1 = a;
    rs2 = b;
    #1;
    chk("busy_c0", busy, 1);
    chk("aluop_m", aluOp, ALU_OP_XXX);
    @(posedge clk);
    #1;
    valid = 1'b0;
    funct3 = 3'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic wait_result(input string nm,
                             input int lat,
                             input logic [31:0] exp);
    int cyc = 1;
    bit got = 0;
    bit bad = 0;
    while (cyc <= 40 && !got) begin
      @(negedge clk);
      if (mdValid) begin
        got = 1;
        chk({nm, "_lat"}, cyc, lat);
        chk({nm, "_res"}, mdResult, exp);
        chk({nm, "_busy_done"}, busy, 0);
      end else begin
        if (!busy) bad = 1;
        cyc++;
      end
    end
    chk({nm, "_seen"}, got, 1);
    chk({nm, "_stall"}, bad, 0);
  endtask

  vec_t vt[$];
  dec_t dt[$];

  initial begin
    bit seen;
    vt.push_back('{"mul",    3'd0, 32'd7, 32'hFFFFFFFD,
                   32'hFFFFFFEB, 33});
    vt.push_back('{"mulh",   3'd1, 32'h80000000, 32'h80000000,
                   32'h40000000, 33});
    vt.push_back('{"mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 33});
    vt.push_back('{"mulhsu", 3'd2, 32'hFFFFFFFF, 32'h2,
                   32'hFFFFFFFF, 33});
    vt.push_back('{"div",    3'd4, 32'hFFFFFFF9, 32'h2,
                   32'hFFFFFFFD, 33});
    vt.push_back('{"rem",    3'd6, 32'hFFFFFFF9, 32'h2,
                   32'hFFFFFFFF, 33});
    vt.push_back('{"divu",   3'd5, 32'd100, 32'd7, 32'd14, 33});
    vt.push_back('{"remu",   3'd7, 32'd100, 32'd7, 32'd2, 33});
    vt.push_back('{"divu0",  3'd5, 32'd5, 32'd0,
                   32'hFFFFFFFF, 1});
    vt.push_back('{"rem0",   3'd6, 32'd5, 32'd0, 32'd5, 1});
    vt.push_back('{"divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF,
                   32'h80000000, 1});
    vt.push_back('{"removf", 3'd6, 32'h80000000, 32'hFFFFFFFF,
                   32'h0, 1});

    dt.push_back('{2'b01, 3'b000, 7'h00, ALU_OP_EQ});
    dt.push_back('{2'b01, 3'b001, 7'h00, ALU_OP_NEQ});
    dt.push_back('{2'b01, 3'b100, 7'h00, ALU_OP_SLT});
    dt.push_back('{2'b01, 3'b101, 7'h00, ALU_OP_GE});
    dt.push_back('{2'b01, 3'b110, 7'h00, ALU_OP_SLTU});
    dt.push_back('{2'b01, 3'b111, 7'h00, ALU_OP_GEU});
    dt.push_back('{2'b01, 3'b010, 7'h00, ALU_OP_XXX});
    dt.push_back('{2'b10, 3'b000, 7'h20, 4'b1000});
    dt.push_back('{2'b10, 3'b101, 7'h00, 4'b0101});
    dt.push_back('{2'b10, 3'b101, 7'h20, 4'b1101});
    dt.push_back('{2'b00, 3'b110, 7'h20, ALU_OP_ADD});

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_mdvalid", mdValid, 0);
    chk("rst_mdresult", mdResult, 0);
    rst_n = 1'b1;

    foreach (dt[i]) begin
      @(negedge clk);
      valid = 1'b1;
      aluCtrlOp = dt[i].op;
      funct3 = dt[i].f;
      funct7 = dt[i].f7;
      #1;
      chk("dec_aluop", aluOp, dt[i].exp);
      chk("dec_busy", busy, 0);
      @(posedge clk);
      #1;
      chk("dec_ready", ready, 1);
      chk("dec_busy_after", busy, 0);
    end
    valid = 1'b0;
    funct7 = 7'h01;

    foreach (vt[i]) begin
      issue(vt[i].f, vt[i].a, vt[i].b);
      wait_result(vt[i].nm, vt[i].lat, vt[i].exp);
    end

    // flush part way through a divide, then a fresh multiply
    seen = 0;
    issue(3'd4, 32'd1000, 32'd3);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (mdValid) seen = 1;
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    if (mdValid) seen = 1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_ready", ready, 1);
    chk("flush_busy", busy, 0);
    issue(3'd0, 32'd7, 32'hFFFFFFFD);
    wait_result("flush_mul", 33, 32'hFFFFFFEB);
    chk("flush_no_valid", seen, 0);

    // same again with a reset instead of a flush
    seen = 0;
    issue(3'd5, 32'd1000, 32'd3);
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      if (mdValid) seen = 1;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rstm_ready", ready, 1);
    chk("rstm_busy", busy, 0);
    chk("rstm_mdresult", mdResult, 0);
    issue(3'd1, 32'h80000000, 32'h80000000);
    wait_result("rstm_mulh", 33, 32'h40000000);
    chk("rstm_no_valid", seen, 0);

    // flush against an accept candidate: nothing is taken
    @(negedge clk);
    valid = 1'b1;
    aluCtrlOp = 2'b11;
    funct3 = 3'd0;
    flush = 1'b1;
    #1;
    chk("flacc_busy", busy, 0);
    @(posedge clk);
    #1;
    valid = 1'b0;
    flush = 1'b0;
    chk("flacc_ready", ready, 1);
    @(negedge clk);
    chk("flacc_mdvalid", mdValid, 0);

    // flush in the result cycle of a special-case divide
    issue(3'd7, 32'd9, 32'd0);
    flush = 1'b1;
    #1;
    chk("fldone_mdvalid", mdValid, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fldone_ready", ready, 1);
    chk("fldone_mdvalid2", mdValid, 0);

    // random ops against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      int lat;
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      lat = 33;
      if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000
                              && b == 32'hFFFFFFFF)))
        lat = 1;
      issue(f, a, b);
      wait_result($sformatf("rand%0d_f%0d", n, f), lat,
                  ref_md(f, a, b));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
